// File: rtl/pipeline_result_collector.sv
// pipeline_result_collector
//
// Pops per-batch {pcoeffSum, pcoeffCount} results from the permute pipeline's
// results FIFO and accumulates a host-chosen number of batches into one wide
// job total, which is then offered on a valid/ready port.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   jobStart            job request, sampled only while jobReady is high
//   jobBatchCount[15:0] number of FIFO results belonging to the job
//   jobReady            block is idle and will accept jobStart
//   resultsAvailable    results FIFO is non-empty
//   grabResults         FIFO read request (combinational)
//   pcoeffSum/Count     FIFO read data, READ_LATENCY cycles after a grab
//   totalValid/Ready    job total handshake
//   totalSum/Count      job totals, stable while totalValid is high
//   overflow            sticky accumulator carry-out flag, cleared by rst
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for jobStart, jobReady high
// COLLECT | issuing grabs while results are still owed to the job
// DRAIN   | all grabs issued, accumulating the reads still in flight
// PRESENT | total offered downstream, held until accepted

`ifndef PCOEFF_COUNT_BITWIDTH
`define PCOEFF_COUNT_BITWIDTH 8
`endif

module pipeline_result_collector #(
  parameter int COUNT_WIDTH    = `PCOEFF_COUNT_BITWIDTH,
  parameter int READ_LATENCY   = 2,  // legal 1..4
  parameter int ACC_EXTRA_BITS = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      jobStart,
  input  logic [15:0]                               jobBatchCount,
  output logic                                      jobReady,
  input  logic                                      resultsAvailable,
  output logic                                      grabResults,
  input  logic [COUNT_WIDTH+35-1:0]                 pcoeffSum,
  input  logic [COUNT_WIDTH-1:0]                    pcoeffCount,
  output logic                                      totalValid,
  input  logic                                      totalReady,
  output logic [COUNT_WIDTH+35+ACC_EXTRA_BITS-1:0]  totalSum,
  output logic [COUNT_WIDTH+ACC_EXTRA_BITS-1:0]     totalCount,
  output logic                                      overflow
);

  localparam int SUM_IN_W = COUNT_WIDTH + 35;
  localparam int SUM_W    = SUM_IN_W + ACC_EXTRA_BITS;
  localparam int CNT_W    = COUNT_WIDTH + ACC_EXTRA_BITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [15:0]             to_request_q, to_request_d;
  logic [15:0]             to_receive_q, to_receive_d;
  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic                    grab;
  logic                    data_cycle;
  logic [SUM_W:0]          sum_add;
  logic [CNT_W:0]          count_add;

  // One extra bit on each adder captures the carry out of the accumulator MSB.
  assign sum_add   = {1'b0, sum_q}   + {{(SUM_W + 1 - SUM_IN_W){1'b0}}, pcoeffSum};
  assign count_add = {1'b0, count_q} + {{(CNT_W + 1 - COUNT_WIDTH){1'b0}}, pcoeffCount};

  assign grab = (state_q == ST_COLLECT) && resultsAvailable && (to_request_q != 16'd0);

  // The state qualifier is redundant by construction; it keeps stale read data
  // from ever touching the totals if the pipe and the FSM disagree.
  assign data_cycle = inflight_q[READ_LATENCY-1] &&
                      ((state_q == ST_COLLECT) || (state_q == ST_DRAIN));

  always_comb begin
    state_d      = state_q;
    to_request_d = to_request_q;
    to_receive_d = to_receive_q;
    sum_d        = sum_q;
    count_d      = count_q;
    overflow_d   = overflow_q;

    // In-flight tracker: bit k set means a grab issued k+1 cycles ago.
    inflight_d    = '0;
    inflight_d[0] = grab;
    for (int i = 1; i < READ_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end

    if (data_cycle) begin
      sum_d        = sum_add[SUM_W-1:0];
      count_d      = count_add[CNT_W-1:0];
      overflow_d   = overflow_q | sum_add[SUM_W] | count_add[CNT_W];
      to_receive_d = to_receive_q - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (jobStart) begin
          to_request_d = jobBatchCount;
          to_receive_d = jobBatchCount;
          sum_d        = '0;
          count_d      = '0;
          state_d      = (jobBatchCount == 16'd0) ? ST_PRESENT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (grab) begin
          to_request_d = to_request_q - 16'd1;
          if (to_request_q == 16'd1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (data_cycle && (to_receive_q == 16'd1)) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (totalReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      to_request_q <= '0;
      to_receive_q <= '0;
      inflight_q   <= '0;
      sum_q        <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_request_q <= to_request_d;
      to_receive_q <= to_receive_d;
      inflight_q   <= inflight_d;
      sum_q        <= sum_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign jobReady    = (state_q == ST_IDLE);
  assign totalValid  = (state_q == ST_PRESENT);
  assign grabResults = grab;
  assign totalSum    = sum_q;
  assign totalCount  = count_q;
  assign overflow    = overflow_q;

endmodule
